// File: rtl/rgb_sched_pkg.sv
// rgb_sched_pkg: shared types and constants for the RGB LED scheduler.
// Holds the FSM encoding, channel indices and the PWM period helper.
package rgb_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;

    localparam int RED    = 0;
    localparam int GREEN  = 1;
    localparam int BLUE   = 2;
    localparam int NUM_CH = 3;

    // PWM period in cycles: the counter skips the all-ones value so that
    // the maximum duty is a true always-on level.
    function automatic int pwm_period(input int bits);
        return (1 << bits) - 1;
    endfunction

    localparam int DEF_PWM_BITS   = 8;
    localparam int DEF_PWM_PERIOD = pwm_period(DEF_PWM_BITS);

endpackage

// File: rtl/rgb_pwm_ch.sv
// rgb_pwm_ch: one colour channel of the LED scheduler.
// Holds the job's duty value and compares it against the shared counter.
module rgb_pwm_ch #(
    parameter int PWM_BITS = 8
) (
    input  logic                hw_clk,
    input  logic                hw_rst_n,
    input  logic                load,
    input  logic [PWM_BITS-1:0] duty_in,
    input  logic [PWM_BITS-1:0] cnt_nxt,
    input  logic                en_nxt,
    output logic                pwm
);

    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_eff;

    // The newly accepted duty must already drive the first SHOW cycle.
    assign duty_eff = load ? duty_in : duty_q;

    // Duty capture and registered compare against next cycle's count.
    always_ff @(posedge hw_clk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            duty_q <= '0;
            pwm    <= 1'b0;
        end else begin
            if (load) begin
                duty_q <= duty_in;
            end
            pwm <= en_nxt && (cnt_nxt < duty_eff);
        end
    end

endmodule

// File: rtl/rgb_led_sched.sv
// rgb_led_sched: round-robin owner of the RGB LED, feeding SB_RGBA_DRV.
// Shows one colour job per grant, then blanks for one PWM period.
module rgb_led_sched
    import rgb_sched_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int PWM_BITS  = 8,
    parameter int TICK_DIV  = 12000,
    parameter int HOLD_BITS = 16
) (
    input  logic                             hw_clk,
    input  logic                             hw_rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*3*PWM_BITS-1:0]    req_color,
    input  logic [NUM_REQ*HOLD_BITS-1:0]     req_hold,
    input  logic                             abort,
    output logic                             busy,
    output logic [$clog2(NUM_REQ)-1:0]       active_id,
    output logic                             rgb_en,
    output logic                             rgb0_pwm,
    output logic                             rgb1_pwm,
    output logic                             rgb2_pwm
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = NUM_CH * PWM_BITS;
    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PWM_BITS-1:0] CNT_LAST =
        PWM_BITS'(pwm_period(PWM_BITS) - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    sched_state_t         state;
    logic [IDW-1:0]       last_id;
    logic [IDW-1:0]       grant_id;
    logic                 grant_found;
    logic [CW-1:0]        sel_color;
    logic [HOLD_BITS-1:0] sel_hold;
    logic [HOLD_BITS-1:0] hold_cnt;
    logic [PW-1:0]        presc;
    logic [PWM_BITS-1:0]  cnt;
    logic [PWM_BITS-1:0]  cnt_inc;
    logic [PWM_BITS-1:0]  cnt_nxt;
    logic                 accept;
    logic                 tick;
    logic                 show_done;
    logic                 stay_show;
    logic                 en_nxt;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grant_id    = last_id;
        grant_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!grant_found &&
                req_valid[IDW'((int'(last_id) + i) % NUM_REQ)]) begin
                grant_found = 1'b1;
                grant_id    = IDW'((int'(last_id) + i) % NUM_REQ);
            end
        end
    end

    // Route the winner's colour and hold time to the capture logic.
    always_comb begin
        sel_color = '0;
        sel_hold  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == IDW'(k)) begin
                sel_color = req_color[k*CW +: CW];
                sel_hold  = req_hold[k*HOLD_BITS +: HOLD_BITS];
            end
        end
    end

    // Ready is gated by reset so nothing is granted while held in reset.
    assign accept = grant_found && (state == ST_IDLE) && !abort && hw_rst_n;

    // One-hot accept strobe toward the winning requester.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign tick      = (presc == PRESC_LAST);
    assign show_done = (hold_cnt == '0) ||
                       (tick && (hold_cnt == HOLD_BITS'(1)));
    assign stay_show = (state == ST_SHOW) && !abort && !show_done;
    assign cnt_inc   = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

    // Channels register against the count of the following cycle, so the
    // first SHOW cycle already reflects cnt = 0. A zero hold keeps them dark.
    assign cnt_nxt = stay_show ? cnt_inc : '0;
    assign en_nxt  = accept ? (sel_hold != '0) : stay_show;

    // Scheduler FSM with registered status outputs.
    always_ff @(posedge hw_clk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            state     <= ST_IDLE;
            last_id   <= IDW'(NUM_REQ - 1);
            active_id <= '0;
            hold_cnt  <= '0;
            presc     <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            rgb_en    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_SHOW;
                        last_id   <= grant_id;
                        active_id <= grant_id;
                        hold_cnt  <= sel_hold;
                        presc     <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        rgb_en    <= 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (abort) begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        rgb_en <= 1'b0;
                    end else if (show_done) begin
                        state  <= ST_GAP;
                        cnt    <= '0;
                        rgb_en <= 1'b0;
                    end else begin
                        cnt   <= cnt_inc;
                        presc <= tick ? '0 : presc + 1'b1;
                        if (tick) begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    // The gap reuses cnt to time one full PWM period.
                    if (abort || (cnt == CNT_LAST)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    rgb_en <= 1'b0;
                end
            endcase
        end
    end

    rgb_pwm_ch #(
        .PWM_BITS (PWM_BITS)
    ) u_red (
        .hw_clk   (hw_clk),
        .hw_rst_n (hw_rst_n),
        .load     (accept),
        .duty_in  (sel_color[RED*PWM_BITS +: PWM_BITS]),
        .cnt_nxt  (cnt_nxt),
        .en_nxt   (en_nxt),
        .pwm      (rgb0_pwm)
    );

    rgb_pwm_ch #(
        .PWM_BITS (PWM_BITS)
    ) u_green (
        .hw_clk   (hw_clk),
        .hw_rst_n (hw_rst_n),
        .load     (accept),
        .duty_in  (sel_color[GREEN*PWM_BITS +: PWM_BITS]),
        .cnt_nxt  (cnt_nxt),
        .en_nxt   (en_nxt),
        .pwm      (rgb1_pwm)
    );

    rgb_pwm_ch #(
        .PWM_BITS (PWM_BITS)
    ) u_blue (
        .hw_clk   (hw_clk),
        .hw_rst_n (hw_rst_n),
        .load     (accept),
        .duty_in  (sel_color[BLUE*PWM_BITS +: PWM_BITS]),
        .cnt_nxt  (cnt_nxt),
        .en_nxt   (en_nxt),
        .pwm      (rgb2_pwm)
    );

endmodule

// File: tb/tb_rgb_led_sched.sv
// tb_rgb_led_sched: randomized self-checking bench for rgb_led_sched.
// Expected outputs come from a job-timeline model of the scheduler.
module tb_rgb_led_sched;

    localparam int NR  = 2;
    localparam int PB  = 8;
    localparam int TD  = 16;
    localparam int HB  = 16;
    localparam int PER = 255;

    logic              hw_clk = 1'b0;
    logic              hw_rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*3*PB-1:0] req_color = '0;
    logic [NR*HB-1:0]  req_hold = '0;
    logic              abort = 1'b0;
    logic              busy;
    logic [0:0]        active_id;
    logic              rgb_en;
    logic              rgb0_pwm;
    logic              rgb1_pwm;
    logic              rgb2_pwm;

    int n_checks = 0;
    int n_fail   = 0;
    int m_last   = NR - 1;

    rgb_led_sched #(
        .NUM_REQ   (NR),
        .PWM_BITS  (PB),
        .TICK_DIV  (TD),
        .HOLD_BITS (HB)
    ) dut (
        .hw_clk    (hw_clk),
        .hw_rst_n  (hw_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_color (req_color),
        .req_hold  (req_hold),
        .abort     (abort),
        .busy      (busy),
        .active_id (active_id),
        .rgb_en    (rgb_en),
        .rgb0_pwm  (rgb0_pwm),
        .rgb1_pwm  (rgb1_pwm),
        .rgb2_pwm  (rgb2_pwm)
    );

    always #5 hw_clk = ~hw_clk;

    // Model: first valid requester after the last grant, or -1.
    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int i = 1; i <= NR; i++) begin
            int k;
            k = (last + i) % NR;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int w);
        logic [NR-1:0] r;
        r = '0;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    // Model: {busy, rgb_en, blue, green, red} t cycles after accept.
    function automatic logic [4:0] exp_out(input int t, input int h,
                                           input logic [23:0] col);
        int  s;
        int  ph;
        logic r;
        logic g;
        logic b;
        s  = (h == 0) ? 1 : h * TD;
        ph = (t - 1) % PER;
        if (t <= s) begin
            r = (h != 0) && (ph < int'(col[7:0]));
            g = (h != 0) && (ph < int'(col[15:8]));
            b = (h != 0) && (ph < int'(col[23:16]));
            return {1'b1, 1'b1, b, g, r};
        end
        if (t <= s + PER) return 5'b10000;
        return 5'b00000;
    endfunction

    function automatic logic [4:0] obs();
        return {busy, rgb_en, rgb2_pwm, rgb1_pwm, rgb0_pwm};
    endfunction

    task automatic step();
        @(posedge hw_clk);
        #1;
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        req_color = {24'hFFFFFF, 24'hFFFFFF};
        req_hold  = {16'd3, 16'd3};
        #12;
        n_checks++;
        if (obs() !== 5'b0 || req_ready !== 2'b00 || active_id !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vals: out=%b ready=%b id=%b want 00000/00/0",
                     obs(), req_ready, active_id);
        end
        @(negedge hw_clk);
        hw_rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_first_ready: got %b want 01", req_ready);
        end
        step();
        m_last = 0;
        n_checks++;
        if (busy !== 1'b1 || rgb_en !== 1'b1 || active_id !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_grant: busy=%b en=%b id=%b want 1/1/0",
                     busy, rgb_en, active_id);
        end
        abort     = 1'b1;
        req_valid = '0;
        step();
        abort = 1'b0;
        @(negedge hw_clk);
        n_checks++;
        if (obs() !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_cleanup: got %b want 00000", obs());
        end
        step();
    endtask

    task automatic test_abort_idle();
        req_valid = 2'b01;
        req_color = {24'h123456, 24'h0080FF};
        req_hold  = {16'd1, 16'd1};
        abort     = 1'b1;
        @(negedge hw_clk);
        n_checks++;
        if (req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_idle_block: ready=%b want 00", req_ready);
        end
        step();
        abort = 1'b0;
        @(negedge hw_clk);
        n_checks++;
        if (req_ready !== 2'b01 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle_next: ready=%b busy=%b want 01/0",
                     req_ready, busy);
        end
        step();
        m_last    = 0;
        req_valid = '0;
        abort     = 1'b1;
        @(negedge hw_clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_idle_accept: busy=%b want 1", busy);
        end
        step();
        abort = 1'b0;
        @(negedge hw_clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle_drop: busy=%b want 0", busy);
        end
        step();
    endtask

    task automatic test_random_jobs(input int njobs);
        for (int j = 0; j < njobs; j++) begin
            logic [NR-1:0] v;
            logic [23:0]   col [NR];
            int            h [NR];
            int            w;
            int            s;
            v = (j < 4) ? 2'b11 : NR'($urandom_range(1, 3));
            for (int k = 0; k < NR; k++) begin
                col[k] = 24'($urandom);
                if ($urandom_range(0, 3) == 0) col[k][7:0] = 8'hFF;
                if ($urandom_range(0, 3) == 0) col[k][15:8] = 8'h00;
                h[k] = $urandom_range(0, 3);
                req_color[k*24 +: 24] = col[k];
                req_hold[k*HB +: HB]  = HB'(h[k]);
            end
            req_valid = v;
            w = rr_pick(v, m_last);
            @(negedge hw_clk);
            n_checks++;
            if (req_ready !== onehot(w) || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_grant job %0d: ready=%b busy=%b want %b/0",
                         j, req_ready, busy, onehot(w));
            end
            step();
            m_last = w;
            s = (h[w] == 0) ? 1 : h[w] * TD;
            for (int t = 1; t <= s + PER; t++) begin
                logic [4:0] e;
                e = exp_out(t, h[w], col[w]);
                @(negedge hw_clk);
                n_checks++;
                if (obs() !== e || req_ready !== 2'b00 ||
                    active_id !== 1'(w)) begin
                    n_fail++;
                    $display("FAIL job %0d t=%0d: out=%b rdy=%b id=%b want %b/00/%0d",
                             j, t, obs(), req_ready, active_id, e, w);
                end
                step();
            end
        end
        req_valid = '0;
    endtask

    task automatic test_color();
        int n_r;
        int n_g;
        int n_b;
        int n_en;
        int n_gap;
        n_r = 0; n_g = 0; n_b = 0; n_en = 0; n_gap = 0;
        req_valid = 2'b10;
        req_color[24 +: 24] = 24'h0080FF;
        req_hold[HB +: HB]  = 16'd2;
        @(negedge hw_clk);
        n_checks++;
        if (req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL color_ready: got %b want 10", req_ready);
        end
        step();
        m_last    = 1;
        req_valid = '0;
        for (int t = 1; t <= 2 * TD + PER; t++) begin
            @(negedge hw_clk);
            n_r   += int'(rgb0_pwm);
            n_g   += int'(rgb1_pwm);
            n_b   += int'(rgb2_pwm);
            n_en  += int'(rgb_en);
            n_gap += int'(busy && !rgb_en);
            step();
        end
        n_checks++;
        if (n_en != 32) begin
            n_fail++;
            $display("FAIL color_show_len: got %0d want 32", n_en);
        end
        n_checks++;
        if (n_r != 32) begin
            n_fail++;
            $display("FAIL color_red: got %0d want 32", n_r);
        end
        n_checks++;
        if (n_g != 32) begin
            n_fail++;
            $display("FAIL color_green: got %0d want 32", n_g);
        end
        n_checks++;
        if (n_b != 0) begin
            n_fail++;
            $display("FAIL color_blue: got %0d want 0", n_b);
        end
        n_checks++;
        if (n_gap != PER) begin
            n_fail++;
            $display("FAIL color_gap_len: got %0d want %0d", n_gap, PER);
        end
        @(negedge hw_clk);
        n_checks++;
        if (busy !== 1'b0 || rgb_en !== 1'b0) begin
            n_fail++;
            $display("FAIL color_end: busy=%b en=%b want 0/0", busy, rgb_en);
        end
        step();
    endtask

    task automatic test_hold_zero();
        int n_busy;
        int n_pwm;
        int fall_t;
        n_busy = 0; n_pwm = 0; fall_t = -1;
        req_valid = 2'b01;
        req_color[0 +: 24] = 24'hFFFFFF;
        req_hold[0 +: HB]  = 16'd0;
        @(negedge hw_clk);
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL hold0_ready: got %b want 01", req_ready);
        end
        step();
        m_last    = 0;
        req_valid = '0;
        for (int t = 1; t <= 300; t++) begin
            @(negedge hw_clk);
            if (t == 1) begin
                n_checks++;
                if (busy !== 1'b1 || {rgb2_pwm, rgb1_pwm, rgb0_pwm} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL hold0_show: busy=%b pwm=%b want 1/000",
                             busy, {rgb2_pwm, rgb1_pwm, rgb0_pwm});
                end
            end
            n_busy += int'(busy);
            n_pwm  += int'(rgb0_pwm | rgb1_pwm | rgb2_pwm);
            if (fall_t < 0 && busy === 1'b0) fall_t = t;
            step();
        end
        n_checks++;
        if (n_busy != PER + 1 || n_pwm != 0 || fall_t != PER + 2) begin
            n_fail++;
            $display("FAIL hold0_len: busy_cyc=%0d pwm_cyc=%0d fall=%0d want %0d/0/%0d",
                     n_busy, n_pwm, fall_t, PER + 1, PER + 2);
        end
    endtask

    task automatic test_abort_show();
        int w;
        int w2;
        req_valid = 2'b11;
        req_color = {24'hFFFFFF, 24'hFFFFFF};
        req_hold  = {16'd3, 16'd3};
        w = rr_pick(2'b11, m_last);
        @(negedge hw_clk);
        n_checks++;
        if (req_ready !== onehot(w)) begin
            n_fail++;
            $display("FAIL abort_show_ready: got %b want %b", req_ready, onehot(w));
        end
        step();
        m_last = w;
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (obs() !== 5'b11111) begin
            n_fail++;
            $display("FAIL abort_show_pre: got %b want 11111", obs());
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        w2 = rr_pick(2'b11, m_last);
        @(negedge hw_clk);
        n_checks++;
        if (obs() !== 5'b0 || req_ready !== onehot(w2)) begin
            n_fail++;
            $display("FAIL abort_show_drop: out=%b ready=%b want 00000/%b",
                     obs(), req_ready, onehot(w2));
        end
        step();
        m_last = w2;
        @(negedge hw_clk);
        n_checks++;
        if (busy !== 1'b1 || active_id !== 1'(w2)) begin
            n_fail++;
            $display("FAIL abort_show_next: busy=%b id=%b want 1/%0d",
                     busy, active_id, w2);
        end
        step();
        req_valid = '0;
        abort     = 1'b1;
        step();
        abort = 1'b0;
        @(negedge hw_clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_show_end: busy=%b want 0", busy);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int w;
        int n_busy;
        n_busy = 0;
        req_valid = 2'b11;
        req_color = {24'hFFFFFF, 24'hFFFFFF};
        req_hold  = {16'd3, 16'd3};
        w = rr_pick(2'b11, m_last);
        @(negedge hw_clk);
        n_checks++;
        if (req_ready !== onehot(w)) begin
            n_fail++;
            $display("FAIL rstmid_ready: got %b want %b", req_ready, onehot(w));
        end
        step();
        m_last = w;
        step();
        step();
        n_checks++;
        if (obs() !== 5'b11111) begin
            n_fail++;
            $display("FAIL rstmid_pre: got %b want 11111", obs());
        end
        #2;
        hw_rst_n  = 1'b0;
        req_valid = '0;
        #1;
        n_checks++;
        if (obs() !== 5'b0 || req_ready !== 2'b00 || active_id !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: out=%b ready=%b id=%b want 00000/00/0",
                     obs(), req_ready, active_id);
        end
        step();
        @(negedge hw_clk);
        hw_rst_n = 1'b1;
        m_last   = NR - 1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_busy += int'(busy);
        end
        n_checks++;
        if (n_busy != 0) begin
            n_fail++;
            $display("FAIL rstmid_reserve: busy_cyc=%0d want 0", n_busy);
        end
        req_valid = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL rstmid_rr: ready=%b want 01", req_ready);
        end
        req_valid = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_abort_idle();
        test_random_jobs(8);
        test_color();
        test_hold_zero();
        test_abort_show();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_led_sched.md
# rgb_led_sched

Round-robin scheduler that shares the on-board RGB LED between `NUM_REQ` requesters. It sits directly in front of the `SB_RGBA_DRV` primitive in the top level. It accepts colour-plus-duration jobs over a valid/ready handshake. For each accepted job it generates the three PWM streams and the driver enable for the programmed hold time, then blanks the LED for one PWM period before serving the next requester.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2..4).
- `PWM_BITS`, 8: duty resolution per channel.
- `TICK_DIV`, 12000: `hw_clk` cycles per hold tick (1 ms at 12 MHz).
- `HOLD_BITS`, 16: hold-time width in ticks.

Ports:
- `hw_clk`  in  1  system clock; single clock domain.
- `hw_rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  job request per requester.
- `req_ready`  out  NUM_REQ  one-hot accept strobe.
- `req_color`  in  NUM_REQ*3*PWM_BITS  per requester, duty values {blue, green, red}; red is at the LSBs.
- `req_hold`  in  NUM_REQ*HOLD_BITS  hold time in ticks.
- `abort`  in  1  single-cycle cancel of the current job.
- `busy`  out  1  high in any state other than IDLE.
- `active_id`  out  clog2(NUM_REQ)  index of the current or last granted requester.
- `rgb_en`  out  1  drives RGBLEDEN and CURREN.
- `rgb0_pwm`, `rgb1_pwm`, `rgb2_pwm`  out  1  each; red, green and blue respectively.

## Operation
- FSM states: IDLE, SHOW, GAP.
- IDLE
  - Outputs and `rgb_en` are 0.
  - If any `req_valid` is high and `abort` is low, a round-robin pick is made. The search starts at `last_id+1` (mod NUM_REQ).
  - `req_ready[k]` for the winner is driven combinationally in the same cycle. The handshake completes when valid and ready are both high.
  - In the accept cycle the block captures that requester's colour and hold, sets `last_id` and `active_id` to k, and moves to SHOW.
- SHOW
  - PWM counter `cnt` runs 0..2^PWM_BITS-2 and wraps, giving a 255-cycle period at 8 bits.
  - Channel output is `cnt < duty`. Duty 0 is always off; duty 255 is always on.
  - `rgb_en` is 1.
  - A prescaler counts TICK_DIV cycles per tick. The hold counter decrements on each tick. When it reaches 0, the FSM moves to GAP.
  - A hold value of 0 goes to GAP after one cycle of SHOW with all outputs off.
- GAP
  - Outputs are 0 and `rgb_en` is 0.
  - Lasts exactly 2^PWM_BITS-1 cycles, then the FSM moves to IDLE.
- `abort`
  - In SHOW or GAP: the FSM moves to IDLE on the next edge, and outputs and `rgb_en` are 0 from that edge.
  - In IDLE: `abort` blocks acceptance in that cycle, and all `req_ready` stay 0.
- `req_ready` is never high outside IDLE. Requesters hold data stable until ready.
- Arithmetic:
  - All counters are unsigned.
  - `cnt` and the prescaler clear on entry to SHOW.
  - No counter saturates; wrap behaviour is defined only for `cnt`.

## Timing
- Reset values (asynchronous on `hw_rst_n` low):
  - state = IDLE.
  - `req_ready`, `busy`, `rgb_en` and all pwm outputs = 0.
  - `active_id` = 0.
  - `last_id` = NUM_REQ-1, so requester 0 wins first.
- Accept in cycle N:
  - `busy` and `rgb_en` are high from N+1.
  - The pwm outputs are registered and first reflect `cnt`=0 at N+1.
- SHOW lasts `hold`*TICK_DIV cycles, or 1 cycle when hold is 0.
- Earliest next accept: GAP end + 1 cycle.
- Reset asserted mid-job: all outputs drop immediately. The captured job is discarded and is not re-served.

## Structure
- Shared package/include `rgb_sched_pkg`:
  - State encoding.
  - Channel index constants: RED=0, GREEN=1, BLUE=2.
  - PWM period constant 2^PWM_BITS-1.
- Sub-module `rgb_pwm_ch`: duty register and comparator against the shared `cnt`, with a registered output. It is instantiated three times.
- Top-level wiring: `rgb_led_sched` feeds `SB_RGBA_DRV` RGB0PWM/RGB1PWM/RGB2PWM and RGBLEDEN/CURREN.

## Test plan
- Reset with `req_valid`=2'b11 → `req_ready`=2'b01 in the first cycle after reset release, then `active_id`=0. After the job plus GAP, `req_ready`=2'b10, so service alternates 0,1,0,1.
- Colour {0x00,0x80,0xFF}, hold=2, TICK_DIV=16 → SHOW lasts 32 cycles with red always high, green high for 128 of each 255 cycles (phase permitting) and blue 0. This is followed by 255 cycles of all-off.
- Hold=0 → one SHOW cycle with all outputs 0, then 255 GAP cycles, then `busy` falls.
- `abort` 5 cycles into SHOW → `busy`, `rgb_en` and all pwm outputs are 0 one cycle later. The next pending request is accepted the cycle after that.
- `abort` high in IDLE with `req_valid`=1 → `req_ready` stays 0 that cycle and asserts the next cycle.
- `hw_rst_n` pulsed low mid-SHOW → all outputs are 0 asynchronously and the FSM is in IDLE. The same requester is not treated as still granted.
